i2s_rx_deserializer: RTL and testbench

- I2S receive path: samples the external codec's SCLK, LRCLK and Din in the system CLK domain, then deserializes one left and one right word per frame.
- Presents each completed stereo pair on a valid/ready stream and through a small Avalon-MM readback window.
- Sits beside the existing I2S transmit block and shares the codec's SCLK/LRCLK.
- Left-channel data doubles as a capture source for the sample RAM.

---
 rtl/i2s_rx_deserializer.sv | 180 ++++++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer: captures left/right words from a codec and presents stereo pairs
// on a valid/ready stream and an Avalon-MM window. Define I2S_RX_LJ_FORMAT_EN for left-justified input.
module i2s_rx_deserializer #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              Din,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              frame_err,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata
);

    // state | meaning
    // IDLE  | wait for first LRCLK edge after reset
    // DELAY | skip the I2S delay bit (previous word's LSB)
    // SHIFT | capture DATA_W bits MSB first
    // PAD   | ignore remaining bits of the slot
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_SHIFT, ST_PAD} state_t;

`ifdef I2S_RX_LJ_FORMAT_EN
    localparam bit LJ_FMT = 1'b1;
`else
    localparam bit LJ_FMT = 1'b0;
`endif

    localparam logic [4:0] LAST_BIT = 5'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] lr_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   sclk_prev_q;
    logic                   lr_prev_q;
    state_t                 state_q;
    logic                   chan_q;
    logic [DATA_W-1:0]      shift_q;
    logic [4:0]             bit_cnt_q;
    logic [DATA_W-1:0]      left_hold_q;
    logic [DATA_W-1:0]      right_hold_q;
    logic                   left_ok_q;
    logic                   pair_stb_q;
    logic [DATA_W-1:0]      sample_left_q;
    logic [DATA_W-1:0]      sample_right_q;
    logic                   sample_valid_q;
    logic                   overrun_q;
    logic                   frame_err_q;

    logic              sclk_s, lr_s, din_s;
    logic              sclk_rise, lr_edge;
    logic [DATA_W-1:0] shift_d;
    logic              consume, clr_ovr, clr_ferr;
    logic              unused_wdata;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign lr_s      = lr_sync_q[SYNC_STAGES-1];
    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign lr_edge   = lr_s ^ lr_prev_q;
    assign shift_d   = {shift_q[DATA_W-2:0], din_s};

    assign consume  = (sample_valid_q & sample_ready) | (avs_read & (avs_address == 2'd2));
    assign clr_ovr  = avs_write & (avs_address == 2'd0) & avs_writedata[1];
    assign clr_ferr = avs_write & (avs_address == 2'd0) & avs_writedata[2];
    assign unused_wdata = ^{avs_writedata[31:3], avs_writedata[0]};

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sclk_sync_q    <= '0;
            lr_sync_q      <= '0;
            din_sync_q     <= '0;
            sclk_prev_q    <= 1'b0;
            lr_prev_q      <= 1'b0;
            state_q        <= ST_IDLE;
            chan_q         <= 1'b0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            left_hold_q    <= '0;
            right_hold_q   <= '0;
            left_ok_q      <= 1'b0;
            pair_stb_q     <= 1'b0;
            sample_left_q  <= '0;
            sample_right_q <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], LRCLK};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], Din};
            sclk_prev_q <= sclk_s;
            pair_stb_q  <= 1'b0;

            // Clears sit before the sets below so a coincident set wins.
            if (clr_ovr)  overrun_q   <= 1'b0;
            if (clr_ferr) frame_err_q <= 1'b0;

            if (sclk_rise) begin
                lr_prev_q <= lr_s;
                if (lr_edge && (state_q != ST_DELAY)) begin
                    chan_q <= lr_s;
                    if (state_q == ST_SHIFT) begin
                        frame_err_q <= 1'b1;
                        left_ok_q   <= 1'b0;
                    end
                    if (LJ_FMT) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= 5'd1;
                        state_q   <= ST_SHIFT;
                    end else begin
                        state_q   <= ST_DELAY;
                    end
                end else begin
                    case (state_q)
                        ST_DELAY: begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= 5'd1;
                            state_q   <= ST_SHIFT;
                        end
                        ST_SHIFT: begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= ST_PAD;
                                if (!chan_q) begin
                                    left_hold_q <= shift_d;
                                    left_ok_q   <= 1'b1;
                                end else begin
                                    right_hold_q <= shift_d;
                                    if (left_ok_q) begin
                                        pair_stb_q <= 1'b1;
                                        left_ok_q  <= 1'b0;
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end

            if (pair_stb_q && (!sample_valid_q || consume)) begin
                sample_left_q  <= left_hold_q;
                sample_right_q <= right_hold_q;
                sample_valid_q <= 1'b1;
            end else if (pair_stb_q) begin
                overrun_q      <= 1'b1;
            end else if (consume) begin
                sample_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            2'd0:    avs_readdata = {29'b0, frame_err_q, overrun_q, sample_valid_q};
            2'd1:    avs_readdata = {sample_left_q, {(32-DATA_W){1'b0}}};
            2'd2:    avs_readdata = {sample_right_q, {(32-DATA_W){1'b0}}};
            default: avs_readdata = '0;
        endcase
    end

    assign sample_left  = sample_left_q;
    assign sample_right = sample_right_q;
    assign sample_valid = sample_valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Testbench for i2s_rx_deserializer: drives I2S slots and checks against a slot-level
// model of word capture, pairing and the output handshake.
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;

    localparam int DATA_W    = 24;
    localparam int HALF_SCLK = 180;
`ifdef I2S_RX_LJ_FORMAT_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              SCLK = 1'b0;
    logic              LRCLK = 1'b0;
    logic              Din = 1'b0;
    logic              sample_ready = 1'b0;
    logic              avs_read = 1'b0;
    logic              avs_write = 1'b0;
    logic [1:0]        avs_address = 2'd0;
    logic [31:0]       avs_writedata = 32'd0;
    logic [DATA_W-1:0] sample_left, sample_right;
    logic              sample_valid, overrun, frame_err;
    logic [31:0]       avs_readdata;

    i2s_rx_deserializer #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SCLK(SCLK), .LRCLK(LRCLK), .Din(Din),
        .sample_left(sample_left), .sample_right(sample_right),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .frame_err(frame_err),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata)
    );

    always #10 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Slot-level reference model state
    logic              seg_bits [64];
    logic              m_lr_last, m_active, m_pending, m_left_ok;
    logic [DATA_W-1:0] m_left_word;
    logic              m_valid, m_ovr, m_ferr;
    logic [DATA_W-1:0] m_left, m_right;
    logic [2*DATA_W-1:0] exp_q[$];
    logic [2*DATA_W-1:0] got_q[$];

    always @(posedge CLK)
        if (RESET_N && sample_valid && sample_ready)
            got_q.push_back({sample_left, sample_right});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lr_last = 1'b0; m_active = 1'b0; m_pending = 1'b0; m_left_ok = 1'b0;
        m_left_word = '0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        m_left = '0; m_right = '0;
    endtask

    task automatic deliver(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        if (sample_ready) begin
            exp_q.push_back({l, r});
            m_left = l; m_right = r; m_valid = 1'b0;
        end else if (!m_valid) begin
            m_left = l; m_right = r; m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // A slot starts capturing on an LRCLK change; its word is bits OFF..OFF+DATA_W-1.
    task automatic model_seg(input logic lr, input int n);
        logic [DATA_W-1:0] w;
        if (lr != m_lr_last) begin
            if (m_pending) begin
                m_ferr = 1'b1;
                m_left_ok = 1'b0;
            end
            m_active = 1'b1;
        end
        m_lr_last = lr;
        m_pending = 1'b0;
        if (m_active) begin
            if (n - OFF >= DATA_W) begin
                for (int i = 0; i < DATA_W; i++) w[DATA_W-1-i] = seg_bits[OFF+i];
                if (!lr) begin
                    m_left_ok = 1'b1;
                    m_left_word = w;
                end else if (m_left_ok) begin
                    m_left_ok = 1'b0;
                    deliver(m_left_word, w);
                end
            end else begin
                m_pending = 1'b1;
            end
        end
    endtask

    task automatic send_seg(input logic lr, input logic [DATA_W-1:0] word, input int n, input int wpos);
        for (int i = 0; i < 64; i++) begin
            if (i >= wpos && i < wpos + DATA_W) seg_bits[i] = word[DATA_W-1-(i-wpos)];
            else                                seg_bits[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b0; LRCLK = lr; Din = seg_bits[i];
            #(HALF_SCLK);
            SCLK = 1'b1;
            #(HALF_SCLK);
        end
        model_seg(lr, n);
    endtask

    task automatic frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input int wpos);
        send_seg(1'b0, l, 32, wpos);
        send_seg(1'b1, r, 32, wpos);
    endtask

    task automatic set_ready(input logic v);
        if (v && m_valid) begin
            exp_q.push_back({m_left, m_right});
            m_valid = 1'b0;
        end
        sample_ready = v;
        repeat (2) @(negedge CLK);
    endtask

    task automatic check_status(input string tag);
        repeat (4) @(negedge CLK);
        check({tag, "_valid"}, 64'(sample_valid), 64'(m_valid));
        check({tag, "_overrun"}, 64'(overrun), 64'(m_ovr));
        check({tag, "_frame_err"}, 64'(frame_err), 64'(m_ferr));
        check({tag, "_left"}, 64'(sample_left), 64'(m_left));
        check({tag, "_right"}, 64'(sample_right), 64'(m_right));
    endtask

    task automatic cmp_pairs(input string tag);
        repeat (4) @(negedge CLK);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({tag, "_pair"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge CLK);
        avs_write = 1'b0; avs_writedata = 32'd0;
    endtask

    task automatic avs_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        avs_address = a; avs_read = 1'b1;
        #1;
        check(tag, 64'(avs_readdata), 64'(exp));
        @(negedge CLK);
        avs_read = 1'b0;
        if (a == 2'd2) m_valid = 1'b0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
    endtask

    initial begin
        logic lr;
        int   n;

        // Reset
        model_reset();
        do_reset();
        check_status("reset");
        avs_rd("reset_reg0", 2'd0, 32'd0);

        // Partial frame, then nominal frame with consumer ready
        set_ready(1'b1);
        send_seg(1'b0, DATA_W'($urandom), 10, 1);
        send_seg(1'b1, DATA_W'($urandom), 32, 1);
        frame(24'h123456, 24'hABCDEF, 1);
        cmp_pairs("nominal");
        check_status("nominal");

        // Backpressure across two frames
        set_ready(1'b0);
        frame(24'h123456, 24'hABCDEF, 1);
        frame(24'h111111, 24'h222222, 1);
        check_status("backpressure");
        check("bp_held_left", 64'(sample_left), 64'h123456);
        avs_wr(2'd0, 32'h2);
        m_ovr = 1'b0;
        check_status("ovr_clear");

        // Avalon readback
        avs_rd("avs_addr1", 2'd1, 32'h12345600);
        avs_rd("avs_addr0", 2'd0, {29'b0, m_ferr, m_ovr, m_valid});
        avs_rd("avs_addr3", 2'd3, 32'd0);
        avs_rd("avs_addr2", 2'd2, 32'hABCDEF00);
        check("avs_consume_valid", 64'(sample_valid), 64'(m_valid));
        cmp_pairs("avs");

        // Short left word
        set_ready(1'b1);
        send_seg(1'b0, DATA_W'($urandom), 17, 1);
        send_seg(1'b1, DATA_W'($urandom), 32, 1);
        check_status("short_word");
        cmp_pairs("short_word");
        frame(DATA_W'($urandom), DATA_W'($urandom), 1);
        cmp_pairs("after_short");
        avs_wr(2'd0, 32'h4);
        m_ferr = 1'b0;
        check_status("ferr_clear");

        // Randomized slots: lengths, words, ready level
        lr = 1'b0;
        for (int f = 0; f < 10; f++) begin
            if (f % 2 == 0) set_ready(1'($urandom_range(0, 1)));
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 20) : $urandom_range(26, 32);
            send_seg(lr, DATA_W'($urandom), n, 1);
            lr = ~lr;
        end
        send_seg(1'b0, DATA_W'($urandom), 32, 1);
        send_seg(1'b1, DATA_W'($urandom), 32, 1);
        check_status("random");
        set_ready(1'b1);
        cmp_pairs("random");
        avs_wr(2'd0, 32'h6);
        m_ovr = 1'b0; m_ferr = 1'b0;

        // Left-justified stimulus
        frame(24'h800001, 24'h7FFFFF, 0);
        cmp_pairs("lj_stim");
        check_status("lj_stim");

        // Reset in the middle of a left word
        send_seg(1'b0, DATA_W'($urandom), 12, 1);
        exp_q.delete();
        do_reset();
        check_status("midword_reset");
        send_seg(1'b0, DATA_W'($urandom), 20, 1);
        send_seg(1'b1, DATA_W'($urandom), 32, 1);
        cmp_pairs("post_reset_partial");
        frame(DATA_W'($urandom), DATA_W'($urandom), 1);
        cmp_pairs("post_reset_frame");
        check_status("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
